// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: CHANNELS output registers with write strobes, plus an
// input FIFO fed by an external device and drained by processor loads.
module io_port_bank #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [3:0]                addr,
   input  logic                      WE,
   input  logic                      RE,
   input  logic [WIDTH-1:0]          writedata,
   output logic [WIDTH-1:0]          read,
   input  logic [WIDTH-1:0]          dev_in_data,
   input  logic                      dev_in_valid,
   output logic                      dev_in_ready,
   output logic [CHANNELS*WIDTH-1:0] dev_out,
   output logic [CHANNELS-1:0]       dev_out_strobe
);

   localparam int         PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int         CW        = $clog2(DEPTH + 1);
   localparam logic [3:0] ADDR_FIFO = 4'(CHANNELS);
   localparam logic [3:0] ADDR_STAT = 4'(CHANNELS + 1);

   logic [WIDTH-1:0]    chan_q [CHANNELS];
   logic [CHANNELS-1:0] strobe_q;
   logic [WIDTH-1:0]    mem [DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       count_q;
   logic                underflow_q;

   logic             empty;
   logic             full;
   logic             fifo_sel;
   logic             push;
   logic             pop;
   logic             uflow_set;
   logic             uflow_clr;
   logic [WIDTH-1:0] status;

   assign empty        = (count_q == '0);
   assign full         = (count_q == CW'(DEPTH));
   assign dev_in_ready = !full;
   assign fifo_sel     = (addr == ADDR_FIFO);
   // Push gating uses only registered full, so a pop cannot open a slot in the same cycle.
   assign push         = dev_in_valid && !full;
   assign pop          = RE && fifo_sel && !empty;
   assign uflow_set    = RE && fifo_sel && empty;
   assign uflow_clr    = WE && (addr == ADDR_STAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            chan_q[i] <= '0;
         end
         strobe_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            strobe_q[i] <= WE && (addr == 4'(i));
            if (WE && (addr == 4'(i))) begin
               chan_q[i] <= writedata;
            end
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_dev_out
      assign dev_out[g*WIDTH +: WIDTH] = chan_q[g];
   end

   assign dev_out_strobe = strobe_q;

   // Storage is not reset; clearing the pointers and count discards its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= dev_in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
         if (uflow_set) begin
            underflow_q <= 1'b1;
         end else if (uflow_clr) begin
            underflow_q <= 1'b0;
         end
      end
   end

   always_comb begin
      status            = '0;
      status[0]         = empty;
      status[1]         = full;
      status[2]         = underflow_q;
      status[3 +: CW]   = count_q;
   end

   always_comb begin
      read = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (addr == 4'(i)) begin
            read = chan_q[i];
         end
      end
      if (fifo_sel && !empty) begin
         read = mem[rd_ptr];
      end
      if (addr == ADDR_STAT) begin
         read = status;
      end
   end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: channel stores, FIFO ordering, full/empty,
// underflow, pointer wrap and asynchronous reset.
module tb_io_port_bank;

   localparam int WIDTH    = 32;
   localparam int CHANNELS = 4;
   localparam int DEPTH    = 4;

   logic                      clk;
   logic                      reset;
   logic [3:0]                addr;
   logic                      WE;
   logic                      RE;
   logic [WIDTH-1:0]          writedata;
   logic [WIDTH-1:0]          read;
   logic [WIDTH-1:0]          dev_in_data;
   logic                      dev_in_valid;
   logic                      dev_in_ready;
   logic [CHANNELS*WIDTH-1:0] dev_out;
   logic [CHANNELS-1:0]       dev_out_strobe;

   int errors = 0;
   int checks = 0;

   io_port_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .addr           (addr),
      .WE             (WE),
      .RE             (RE),
      .writedata      (writedata),
      .read           (read),
      .dev_in_data    (dev_in_data),
      .dev_in_valid   (dev_in_valid),
      .dev_in_ready   (dev_in_ready),
      .dev_out        (dev_out),
      .dev_out_strobe (dev_out_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic status_is(input string tag, input logic [WIDTH-1:0] exp);
      addr = 4'd5;
      RE   = 1'b0;
      #1;
      check(tag, read, exp);
   endtask

   task automatic push_word(input logic [WIDTH-1:0] d);
      dev_in_valid = 1'b1;
      dev_in_data  = d;
      tick();
      dev_in_valid = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [WIDTH-1:0] exp);
      addr = 4'd4;
      RE   = 1'b1;
      #1;
      check(tag, read, exp);
      tick();
      RE = 1'b0;
   endtask

   initial begin
      reset        = 1'b0;
      addr         = 4'd0;
      WE           = 1'b0;
      RE           = 1'b0;
      writedata    = '0;
      dev_in_data  = '0;
      dev_in_valid = 1'b0;
      #2 reset = 1'b1;

      // Valid offered during reset must not be accepted.
      dev_in_valid = 1'b1;
      dev_in_data  = 32'hAA;
      tick();
      tick();
      dev_in_valid = 1'b0;
      status_is("reset_status", 32'h01);
      check("reset_ready", 32'(dev_in_ready), 32'd1);
      check("reset_dev_out", 32'(dev_out == '0), 32'd1);
      check("reset_strobe", 32'(dev_out_strobe), 32'd0);
      tick();
      reset = 1'b0;

      // Channel store and strobe.
      WE = 1'b1; addr = 4'd2; writedata = 32'hDEADBEEF;
      tick();
      WE = 1'b0;
      check("ch2_dev_out", dev_out[95:64], 32'hDEADBEEF);
      check("ch2_strobe", 32'(dev_out_strobe), 32'h4);
      #1;
      check("ch2_read", read, 32'hDEADBEEF);
      tick();
      check("ch2_strobe_gone", 32'(dev_out_strobe), 32'h0);
      check("ch0_untouched", dev_out[31:0], 32'h0);

      // Stores to FIFO data and unmapped addresses are ignored.
      WE = 1'b1; addr = 4'd4; writedata = 32'h1234;
      tick();
      addr = 4'd9;
      tick();
      WE = 1'b0;
      status_is("fifo_we_ignored", 32'h01);
      addr = 4'd9;
      #1;
      check("unmapped_read", read, 32'h0);
      check("unmapped_strobe", 32'(dev_out_strobe), 32'h0);

      // Fill with valid held, fifth word held off.
      dev_in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         dev_in_data = 32'(i);
         tick();
      end
      dev_in_data = 32'd5;
      status_is("full_status", 32'h22);
      check("full_ready", 32'(dev_in_ready), 32'd0);
      tick();
      status_is("full_holdoff", 32'h22);
      dev_in_valid = 1'b0;
      pop_expect("pop1", 32'd1);
      pop_expect("pop2", 32'd2);
      pop_expect("pop3", 32'd3);
      pop_expect("pop4", 32'd4);
      status_is("drained_status", 32'h01);

      // Simultaneous push and pop at count 2.
      push_word(32'd10);
      push_word(32'd11);
      dev_in_valid = 1'b1; dev_in_data = 32'd7;
      addr = 4'd4; RE = 1'b1;
      #1;
      check("pushpop_head", read, 32'd10);
      tick();
      dev_in_valid = 1'b0; RE = 1'b0;
      status_is("pushpop_count", 32'h10);
      pop_expect("pushpop_pop11", 32'd11);
      pop_expect("pushpop_pop7", 32'd7);

      // Underflow set and clear.
      addr = 4'd4; RE = 1'b1;
      #1;
      check("empty_read", read, 32'h0);
      tick();
      RE = 1'b0;
      status_is("underflow_set", 32'h05);
      WE = 1'b1; addr = 4'd5; writedata = 32'hFFFFFFFF;
      tick();
      WE = 1'b0;
      status_is("underflow_clr", 32'h01);

      // Fill, pop two, push two, drain across the pointer wrap.
      push_word(32'd21);
      push_word(32'd22);
      push_word(32'd23);
      push_word(32'd24);
      status_is("wrap_full", 32'h22);
      pop_expect("wrap_pop21", 32'd21);
      pop_expect("wrap_pop22", 32'd22);
      push_word(32'd25);
      status_is("wrap_count3", 32'h18);
      push_word(32'd26);
      push_word(32'd27);
      status_is("wrap_capped", 32'h22);
      pop_expect("wrap_pop23", 32'd23);
      pop_expect("wrap_pop24", 32'd24);
      pop_expect("wrap_pop25", 32'd25);
      pop_expect("wrap_pop26", 32'd26);
      status_is("wrap_empty", 32'h01);

      // Asynchronous reset mid-cycle with count 3 and channel 0 loaded.
      WE = 1'b1; addr = 4'd0; writedata = 32'h55;
      tick();
      WE = 1'b0;
      check("ch0_strobe", 32'(dev_out_strobe), 32'h1);
      check("ch0_dev_out", dev_out[31:0], 32'h55);
      push_word(32'd31);
      push_word(32'd32);
      push_word(32'd33);
      status_is("pre_reset_count3", 32'h18);
      #2 reset = 1'b1;
      #1;
      check("async_status", read, 32'h01);
      check("async_ready", 32'(dev_in_ready), 32'd1);
      check("async_dev_out", 32'(dev_out == '0), 32'd1);
      check("async_ch2", dev_out[95:64], 32'h0);
      tick();
      reset = 1'b0;
      push_word(32'h99);
      status_is("post_reset_count1", 32'h08);
      pop_expect("post_reset_head", 32'h99);
      status_is("post_reset_empty", 32'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width of every port, channel and FIFO entry.
REQ-002 SHALL have parameter CHANNELS, default 4, legal range 1..14: number of output channels.
REQ-003 SHALL have parameter DEPTH, default 4, power of two, at least 2: number of entries in the input FIFO.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port addr, input, 4 bits: word index into the block's register map.
REQ-007 SHALL have port WE, input, 1 bit: processor store strobe.
REQ-008 SHALL have port RE, input, 1 bit: processor load strobe; pops the FIFO when addr selects FIFO data.
REQ-009 SHALL have port writedata, input, WIDTH bits: processor store data.
REQ-010 SHALL have port read, output, WIDTH bits: processor load data, combinational from addr and state.
REQ-011 SHALL have port dev_in_data, input, WIDTH bits: word offered by the external device.
REQ-012 SHALL have port dev_in_valid, input, 1 bit: external device offers dev_in_data.
REQ-013 SHALL have port dev_in_ready, output, 1 bit: block accepts the word; equals !full.
REQ-014 SHALL have port dev_out, output, CHANNELS*WIDTH bits: all channel registers concatenated, channel 0 in the LSBs.
REQ-015 SHALL have port dev_out_strobe, output, CHANNELS bits: one-cycle pulse per channel, asserted the cycle after that channel is written.

Function
REQ-016 Register map SHALL be as follows.
- addr 0..CHANNELS-1: channel register.
- addr CHANNELS: FIFO data.
- addr CHANNELS+1: status.
- Any other addr: reads 0, writes ignored.
REQ-017 With WE=1 and addr=k<CHANNELS, channel register k SHALL load writedata at the rising edge; dev_out_strobe[k] SHALL be 1 for exactly the following cycle.
REQ-018 Reading addr k<CHANNELS SHALL return channel register k.
REQ-019 Status word SHALL be as follows.
- bit0: empty.
- bit1: full.
- bit2: sticky underflow.
- bits[2+clog2(DEPTH+1):3]: count.
- Remaining bits: 0.
REQ-020 FIFO push SHALL occur when dev_in_valid and dev_in_ready are both high at a rising edge; the entry is written at the write pointer, which then advances.
REQ-021 Reading addr CHANNELS SHALL return the head entry, first-word fall-through; when empty it SHALL return 0.
REQ-022 FIFO pop SHALL occur when RE=1, addr=CHANNELS and not empty; the read pointer advances at the rising edge.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL range 0..DEPTH.
REQ-024 Simultaneous push and pop SHALL leave count unchanged.
- Valid when not full: a push accepted while count≥1 pops the old head.
- When empty, only the push occurs.
REQ-025 When full, dev_in_ready SHALL be 0 and no push SHALL occur, whatever dev_in_valid is.
- A pop in that same cycle SHALL NOT allow a same-cycle push; ready rises the next cycle.
REQ-026 RE=1 at addr CHANNELS while empty SHALL set the underflow bit and leave pointers unchanged.
REQ-027 WE=1 at the status address SHALL clear underflow; the write data is ignored.
- If an underflow event occurs in the same cycle, set SHALL win.
REQ-028 WE=1 at the FIFO data address SHALL be ignored.
REQ-029 WE and RE asserted together SHALL each act independently per REQ-017 to REQ-027.
REQ-030 dev_in_ready SHALL be a registered-state function (!full), with no combinational path from RE or dev_in_valid.

Reset
REQ-031 On reset assertion, the following SHALL go to 0 immediately, independent of clk:
- all channel registers and dev_out;
- dev_out_strobe;
- FIFO pointers and count;
- underflow.
REQ-032 During reset, empty=1, full=0 and dev_in_ready=1, but no push SHALL occur while reset is high.
REQ-033 Reset asserted mid-transfer SHALL discard all FIFO contents; FIFO storage contents need not be cleared.
REQ-034 The first push or store SHALL take effect at the first rising edge after reset deasserts.

Verification
REQ-035 Reset, then store 0xDEADBEEF to addr 2 -> dev_out[95:64]=0xDEADBEEF next cycle; dev_out_strobe=4'b0100 for one cycle; read at addr 2 returns 0xDEADBEEF.
REQ-036 Push 1,2,3,4 with dev_in_valid held -> after the 4th, status=0x22 (count 4, full) and dev_in_ready=0; a 5th word is held off; four pops return 1,2,3,4; status=0x01.
REQ-037 With count=2, push 7 and pop in the same cycle -> count stays 2; the pop returns the old head; 7 emerges last.
REQ-038 Pop while empty -> read=0; status=0x05; store to addr 5 -> status=0x01.
REQ-039 Fill the FIFO, pop two, push two, then drain -> order preserved across pointer wrap; count never exceeds 4.
REQ-040 Assert reset asynchronously mid-cycle with count=3 and channel 0=0x55 -> status=0x01, dev_out=0 and dev_in_ready=1 before the next edge.
